// File: rtl/seq_det_pkg.sv
// Shared types for the serial "101" detector.
// Holds the state width and the fixed state encoding.
package seq_det_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_10   = 2'b10,
        S_101  = 2'b11
    } state_t;

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating detection counter for seq_det_101.
// Ports: clock, reset (sync, active-high), inc, cnt[CNT_W-1:0].
module seq_det_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic w_full;

    assign w_full = &cnt;

    // Holds at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !w_full) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_det_101.sv
// Overlapping serial "101" Moore detector; det_o = (state == S_101).
// Ports: clock, reset (sync, active-high), seq_in, det_o,
// det_cnt[CNT_W-1:0] only when SEQ_DET_COUNT_EN is defined.
module seq_det_101
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             seq_in,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] det_cnt,
`endif
    output logic             det_o
);

    state_t state;
    state_t w_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= w_next;
        end
    end

    // From S_101 the trailing '1' is reused as a fresh leading '1'.
    always_comb begin
        w_next = S_IDLE;
        case (state)
            S_IDLE:  w_next = seq_in ? S_1   : S_IDLE;
            S_1:     w_next = seq_in ? S_1   : S_10;
            S_10:    w_next = seq_in ? S_101 : S_IDLE;
            S_101:   w_next = seq_in ? S_1   : S_10;
            default: w_next = S_IDLE;
        endcase
    end

    assign det_o = (state == S_101);

`ifdef SEQ_DET_COUNT_EN
    logic w_inc;

    // Counts on the same edge that moves the FSM into S_101.
    assign w_inc = (w_next == S_101);

    seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_inc),
        .cnt   (det_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_det_101.sv
// Scoreboard bench for seq_det_101 using a bit-history reference model.
// Checks state, det_o and (with SEQ_DET_COUNT_EN) det_cnt every cycle.
`timescale 1ns/1ps
module tb_seq_det_101;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [1:0]       st;
        logic             det;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    logic seq_in;
    logic det_o;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] det_cnt;
`endif

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   failures;

    logic [2:0]       m_hist;
    int               m_n;
    logic [CNT_W-1:0] m_cnt;

    seq_det_101 #(
        .CNT_W (CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .seq_in  (seq_in),
`ifdef SEQ_DET_COUNT_EN
        .det_cnt (det_cnt),
`endif
        .det_o   (det_o)
    );

    initial begin
        clock = 1'b0;
        forever #19530 clock = ~clock;
    end

    // Reference model: state is derived from the bits seen since reset.
    task automatic drive(input logic b, input logic rst);
        exp_t x;
        @(negedge clock);
        seq_in = b;
        reset  = rst;
        if (rst) begin
            m_hist = 3'b000;
            m_n    = 0;
            m_cnt  = '0;
        end else begin
            m_hist = {m_hist[1:0], b};
            if (m_n < 3) m_n++;
        end
        if (!rst && m_n >= 3 && m_hist == 3'b101)
            x.st = 2'b11;
        else if (!rst && m_n >= 1 && m_hist[0])
            x.st = 2'b01;
        else if (!rst && m_n >= 2 && m_hist[1:0] == 2'b10)
            x.st = 2'b10;
        else
            x.st = 2'b00;
        x.det = (x.st == 2'b11);
        if (x.det && m_cnt != {CNT_W{1'b1}})
            m_cnt = m_cnt + 1'b1;
        x.cnt = m_cnt;
        sb.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1);
            e = sb.pop_front();
            checks++;
            if (dut.state !== e.st || det_o !== e.det) begin
                failures++;
                $display("FAIL reset[%0d] state=%b det=%b want %b %b",
                         i, dut.state, det_o, e.st, e.det);
            end
`ifdef SEQ_DET_COUNT_EN
            checks++;
            if (det_cnt !== e.cnt) begin
                failures++;
                $display("FAIL reset_cnt[%0d] got=%0d want=%0d",
                         i, det_cnt, e.cnt);
            end
`endif
        end
    endtask

    task automatic test_overlap();
        logic [6:0] pat;
        int pulses;
        pat    = 7'b0101011;
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            drive(pat[i], 1'b0);
            e = sb.pop_front();
            if (det_o === 1'b1) pulses++;
            checks++;
            if (dut.state !== e.st || det_o !== e.det) begin
                failures++;
                $display("FAIL overlap[%0d] state=%b det=%b want %b %b",
                         i, dut.state, det_o, e.st, e.det);
            end
`ifdef SEQ_DET_COUNT_EN
            checks++;
            if (det_cnt !== e.cnt) begin
                failures++;
                $display("FAIL overlap_cnt[%0d] got=%0d want=%0d",
                         i, det_cnt, e.cnt);
            end
`endif
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL overlap_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat;
        int pulses;
        pat    = 4'b1011;
        pulses = 0;
        drive(1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (dut.state !== e.st || det_o !== e.det) begin
            failures++;
            $display("FAIL mid_reset state=%b det=%b want %b %b",
                     dut.state, det_o, e.st, e.det);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(pat[i], 1'b0);
            e = sb.pop_front();
            if (det_o === 1'b1) pulses++;
            checks++;
            if (dut.state !== e.st || det_o !== e.det) begin
                failures++;
                $display("FAIL mid[%0d] state=%b det=%b want %b %b",
                         i, dut.state, det_o, e.st, e.det);
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL mid_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_nonmatch();
        logic [6:0] pat;
        pat = 7'b1100100;
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 6; i >= 0; i--) begin
            drive(pat[i], 1'b0);
            e = sb.pop_front();
            checks++;
            if (dut.state !== e.st || det_o !== 1'b0) begin
                failures++;
                $display("FAIL nonmatch[%0d] state=%b det=%b want %b 0",
                         i, dut.state, det_o, e.st);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (dut.state !== 2'b00 || det_o !== 1'b0 || e.st !== 2'b00) begin
            failures++;
            $display("FAIL rst_prio state=%b det=%b want 00 0",
                     dut.state, det_o);
        end
        drive(1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (dut.state !== e.st || det_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_prio_after state=%b det=%b want %b 0",
                     dut.state, det_o, e.st);
        end
    endtask

    task automatic test_saturation();
        logic [4:0] pat;
        pat = 5'b10100;
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
        for (int k = 0; k < 5; k++) begin
            for (int i = 4; i >= 0; i--) begin
                drive(pat[i], 1'b0);
                e = sb.pop_front();
                checks++;
                if (dut.state !== e.st || det_o !== e.det) begin
                    failures++;
                    $display("FAIL sat[%0d.%0d] state=%b det=%b want %b %b",
                             k, i, dut.state, det_o, e.st, e.det);
                end
            end
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (det_cnt !== 2'd3 || e.cnt !== 2'd3) begin
            failures++;
            $display("FAIL sat_cnt got=%0d want=3", det_cnt);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        seq_in   = 1'b0;
        m_hist   = 3'b000;
        m_n      = 0;
        m_cnt    = '0;
        test_reset();
        test_overlap();
        test_reset_mid();
        test_nonmatch();
        test_reset_priority();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
